// File: rtl/ex.sv
// Execute stage: single-cycle logic/shift results plus an iterative radix-2
// divider that stalls the pipeline and hands HI/LO to write-back when done.
module ex #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } div_state_t;

  logic        start;
  logic        is_div_signed;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] wb_data;

  assign is_div_signed = (aluop_i == EXE_DIV_OP);
  assign start         = is_div_signed || (aluop_i == EXE_DIVU_OP);

  for (genvar gi = 0; gi < 32; gi++) begin : g_logic
    always_comb begin
      case (aluop_i)
        EXE_OR_OP:  logic_res[gi] = reg1_i[gi] | reg2_i[gi];
        EXE_AND_OP: logic_res[gi] = reg1_i[gi] & reg2_i[gi];
        EXE_XOR_OP: logic_res[gi] = reg1_i[gi] ^ reg2_i[gi];
        EXE_NOR_OP: logic_res[gi] = ~(reg1_i[gi] | reg2_i[gi]);
        default:    logic_res[gi] = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = 32'd0;
    endcase
  end

  always_comb begin
    case (alusel_i)
      EXE_RES_LOGIC: wb_data = logic_res;
      EXE_RES_SHIFT: wb_data = shift_res;
      EXE_RES_NOP:   wb_data = 32'd0;
      default:       wb_data = 32'd0;
    endcase
  end

  // Divider datapath
  div_state_t  state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] sr_reg;
  logic [31:0] divisor_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] diff;
  logic [64:0] sr_next;
  logic [31:0] quot_next;
  logic [31:0] rem_next;

  assign op1_abs = (is_div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign op2_abs = (is_div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // sr_reg[64:32] holds the partial remainder already shifted left with the
  // next dividend bit appended; quotient bits enter at sr_reg[0].
  assign diff = sr_reg[64:32] - {1'b0, divisor_reg};

  always_comb begin
    if (diff[32]) begin
      sr_next = {sr_reg[63:0], 1'b0};
    end else begin
      sr_next = {diff[31:0], sr_reg[31:0], 1'b1};
    end
  end

  assign quot_next = sr_next[31:0];
  assign rem_next  = sr_next[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FREE;
      cnt_reg     <= 6'd0;
      sr_reg      <= 65'd0;
      divisor_reg <= 32'd0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      case (state_reg)
        ST_FREE: begin
          if (start) begin
            if (reg2_i == 32'd0) begin
              state_reg <= ST_BYZERO;
            end else begin
              sr_reg      <= {32'd0, op1_abs, 1'b0};
              divisor_reg <= op2_abs;
              q_neg_reg   <= is_div_signed && (reg1_i[31] ^ reg2_i[31]);
              r_neg_reg   <= is_div_signed && reg1_i[31];
              cnt_reg     <= 6'd0;
              state_reg   <= ST_ON;
            end
          end
        end
        ST_BYZERO: begin
          hi_reg    <= 32'd0;
          lo_reg    <= 32'd0;
          state_reg <= ST_END;
        end
        ST_ON: begin
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'(DIV_CYCLES - 1)) begin
            lo_reg    <= q_neg_reg ? (~quot_next + 32'd1) : quot_next;
            hi_reg    <= r_neg_reg ? (~rem_next + 32'd1) : rem_next;
            state_reg <= ST_END;
          end
        end
        ST_END: begin
          state_reg <= ST_FREE;
        end
        default: state_reg <= ST_FREE;
      endcase
    end
  end

  // Reset blanks every output in the same cycle it is asserted.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !start;
      wdata_o    = wb_data;
      whilo_o    = (state_reg == ST_END);
      hi_o       = (state_reg == ST_END) ? hi_reg : 32'd0;
      lo_o       = (state_reg == ST_END) ? lo_reg : 32'd0;
      stallreq_o = start && (state_reg != ST_END);
    end
  end

endmodule

// File: tb/tb_ex.sv
// Bench for ex: directed test-plan cases plus randomized traffic compared each
// cycle against an arithmetic model of the execute stage.
module tb_ex;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  ex dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_start(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [2:0] sel,
                                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (sel == RES_LOGIC) begin
      if (op == EXE_OR_OP)       r = a | b;
      else if (op == EXE_AND_OP) r = a & b;
      else if (op == EXE_XOR_OP) r = a ^ b;
      else if (op == EXE_NOR_OP) r = ~(a | b);
    end else if (sel == RES_SHIFT) begin
      if (op == EXE_SLL_OP)      r = b << a[4:0];
      else if (op == EXE_SRL_OP) r = b >> a[4:0];
      else if (op == EXE_SRA_OP) r = 32'($signed(b) >>> a[4:0]);
    end
    return r;
  endfunction

  // Divider model: cycles remaining until the result cycle, plus the result.
  bit          m_busy = 1'b0;
  bit          m_end  = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  always @(posedge clk) begin
    longint sa, sb;
    if (rst) begin
      m_busy = 1'b0;
      m_end  = 1'b0;
    end else if (m_end) begin
      m_end = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_end  = 1'b1;
      end
    end else if (is_start(aluop)) begin
      m_busy = 1'b1;
      if (reg2 == 32'd0) begin
        m_left = 1;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
      end else begin
        m_left = 32;
        if (aluop == EXE_DIVU_OP) begin
          m_lo = reg1 / reg2;
          m_hi = reg1 % reg2;
        end else begin
          sa   = longint'($signed(reg1));
          sb   = longint'($signed(reg2));
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit st;
    st = is_start(aluop);
    if (rst) begin
      chk("m_wd", {27'd0, wd_o}, 32'd0);
      chk("m_wreg", {31'd0, wreg_o}, 32'd0);
      chk("m_wdata", wdata_o, 32'd0);
      chk("m_whilo", {31'd0, whilo_o}, 32'd0);
      chk("m_hi", hi_o, 32'd0);
      chk("m_lo", lo_o, 32'd0);
      chk("m_stall", {31'd0, stallreq_o}, 32'd0);
    end else begin
      chk("m_wd", {27'd0, wd_o}, {27'd0, wd});
      chk("m_wreg", {31'd0, wreg_o}, {31'd0, wreg && !st});
      chk("m_wdata", wdata_o, model_wdata(aluop, alusel, reg1, reg2));
      chk("m_whilo", {31'd0, whilo_o}, {31'd0, m_end});
      chk("m_hi", hi_o, m_end ? m_hi : 32'd0);
      chk("m_lo", lo_o, m_end ? m_lo : 32'd0);
      chk("m_stall", {31'd0, stallreq_o}, {31'd0, st && !m_end});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
  endtask

  // Issues a divide at the next cycle, holds it while stalled, then checks the
  // stall length and the END-cycle outputs.
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    step();
    apply(op, RES_NOP, a, b, 5'd9, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq_o) begin
        n++;
        step();
      end else begin
        break;
      end
    end
    chk({name, "_stalls"}, n, exp_stalls);
    chk({name, "_whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({name, "_lo"}, lo_o, exp_lo);
    chk({name, "_hi"}, hi_o, exp_hi);
    chk({name, "_wreg"}, {31'd0, wreg_o}, 32'd0);
    $display("div %s a=%h b=%h stalls=%0d lo=%h hi=%h", name, a, b, n, lo_o, hi_o);
  endtask

  logic [7:0] op_tab [0:10];

  initial begin
    int n;
    op_tab = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
               EXE_SRA_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP, 8'hA5};
    rst = 1'b1;
    apply(EXE_DIV_OP, RES_LOGIC, 32'h1234, 32'h5, 5'd3, 1'b1);
    step();
    @(negedge clk);
    chk("reset_stall", {31'd0, stallreq_o}, 32'd0);
    chk("reset_wd", {27'd0, wd_o}, 32'd0);
    $display("reset stall=%b wd=%0d", stallreq_o, wd_o);

    step();
    rst = 1'b0;
    apply(EXE_OR_OP, RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd5, 1'b1);
    @(negedge clk);
    chk("or_wdata", wdata_o, 32'h0000FFFF);
    chk("or_wd", {27'd0, wd_o}, 32'd5);
    chk("or_wreg", {31'd0, wreg_o}, 32'd1);
    chk("or_stall", {31'd0, stallreq_o}, 32'd0);
    $display("or wdata=%h", wdata_o);

    step();
    apply(EXE_SRA_OP, RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1);
    @(negedge clk);
    chk("sra_wdata", wdata_o, 32'hF8000001);
    $display("sra wdata=%h", wdata_o);
    step();
    apply(EXE_SLL_OP, RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1);
    @(negedge clk);
    chk("sll_wdata", wdata_o, 32'h00000100);
    $display("sll wdata=%h", wdata_o);

    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_min_m1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);
    run_div("divu_by0", EXE_DIVU_OP, 32'd55, 32'd0, 2, 32'd0, 32'd0);

    // Flush mid-division: result still appears 33 cycles after issue.
    step();
    apply(EXE_DIVU_OP, RES_NOP, 32'd50, 32'd5, 5'd2, 1'b1);
    repeat (5) step();
    apply(EXE_NOP_OP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (whilo_o) break;
      n++;
      step();
    end
    chk("flush_delay", n, 28);
    chk("flush_lo", lo_o, 32'd10);
    $display("flush delay=%0d lo=%h", n, lo_o);

    // Reset at iteration 10 of a DIV.
    step();
    apply(EXE_DIV_OP, RES_NOP, 32'd1000, 32'd3, 5'd7, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_mid_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_mid_whilo", {31'd0, whilo_o}, 32'd0);
    step();
    rst = 1'b0;
    apply(EXE_NOP_OP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (whilo_o) n++;
      step();
    end
    chk("rst_mid_no_pulse", n, 0);
    $display("reset-mid pulses=%0d", n);
    run_div("div_after_rst", EXE_DIV_OP, 32'd1000, 32'd3, 33, 32'd333, 32'd1);

    // Randomized traffic; a divide is held while the model says it stalls.
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] op;
      logic [31:0] a, b;
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (is_start(aluop) && m_busy && $urandom_range(0, 49) != 0) continue;
      op = op_tab[$urandom_range(0, 10)];
      a = $urandom();
      b = $urandom();
      if (is_start(op)) begin
        case ($urandom_range(0, 5))
          0: b = 32'd0;
          1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
          2: b = $urandom_range(1, 20);
          default: ;
        endcase
      end
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      apply(op, 3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) begin
        if (op inside {EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP}) alusel = RES_LOGIC;
        else if (op inside {EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP}) alusel = RES_SHIFT;
        else alusel = RES_NOP;
      end
    end
    step();
    rst = 1'b0;
    apply(EXE_NOP_OP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (40) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
